acia_tx: RTL and testbench
==========================

# acia_tx

Transmit section of the 6551-compatible ACIA. It sits directly downstream of the baud-rate generator and consumes its 16× bit-rate timing as a one-cycle clock-enable, `TICK16`. It holds one character in a transmit data register (TDR) and serialises characters from a shift register onto `TXD` with framing set by the control and command registers: start bit, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits. It reports holding-register status to the status-register logic through `TDRE`.

## Interface
Parameters
- none; all framing is run-time selectable.

Ports
- `XTLI` in 1 — the single clock; all state updates on its rising edge.
- `RESET` in 1 — synchronous, active-low reset.
- `TICK16` in 1 — one-cycle enable pulse at 16× the bit rate, generated in the `XTLI` domain. Bit timing counts these pulses only.
- `TDR_WR` in 1 — one-cycle write strobe for the TDR.
- `TDR_IN` in 8 — character data, captured on the edge where `TDR_WR`=1.
- `R_WL` in 2 — word length: 00=8, 01=7, 10=6, 11=5 data bits.
- `R_SBN` in 1 — 0 selects 1 stop bit; 1 selects 2 stop bits (exceptions in Operation).
- `R_PME` in 1 — parity enable.
- `R_PMC` in 2 — parity mode: 00 odd, 01 even, 10 mark, 11 space.
- `CTSB` in 1 — active-low clear-to-send.
- `TXD` out 1 — serial output; idles at 1.
- `TDRE` out 1 — TDR empty flag.
- `TX_BUSY` out 1 — 1 while a frame is on the line.

## Operation
- **Storage.** An 8-bit TDR plus a separate 8-bit shift register. `TDR_WR` always loads the TDR and clears `TDRE`. A write while `TDRE`=0 overwrites the pending character; no error flag is raised.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Sub-bit counter.** A 5-bit tick counter counts `TICK16` pulses within the current bit.
- **IDLE.**
  - `TXD`=1.
  - If `TDRE`=0 and `CTSB`=0 at a `TICK16`: copy TDR to the shift register, set `TDRE`=1, clear the tick counter, enter START.
- **START.** `TXD`=0 for 16 ticks, then enter DATA with the bit index at 0.
- **DATA.**
  - `TXD`=shift[0] for 16 ticks, then shift right and increment the index.
  - After N bits (N from `R_WL`), go to PARITY if `R_PME`=1, otherwise STOP.
- **PARITY.** `TXD` for 16 ticks:
  - odd: ~^ of the N data bits;
  - even: ^ of the N data bits;
  - mark: 1;
  - space: 0.
  - Bits above N are ignored.
- **STOP.** `TXD`=1 for the stop length:
  - 16 ticks when `R_SBN`=0;
  - 32 ticks when `R_SBN`=1;
  - exception: 24 ticks (1.5 stop bits) when `R_SBN`=1, N=5 and `R_PME`=0;
  - exception: 16 ticks when `R_SBN`=1, N=8 and `R_PME`=1.
- **End of STOP.**
  - If `TDRE`=0 and `CTSB`=0, reload on the same tick and enter START directly, with no idle gap.
  - Otherwise enter IDLE.
- **`CTSB`.** Sampled only at frame start. Deasserting it mid-frame does not truncate the frame; the transmitter holds in IDLE until `CTSB` returns to 0.
- **Framing inputs.** `R_WL`, `R_SBN`, `R_PME` and `R_PMC` are latched when the shift register loads. Changes mid-frame affect only the next frame.
- **`TX_BUSY`** is 1 in START, DATA, PARITY and STOP.

## Timing
- **Reset.** On any `XTLI` edge with `RESET`=0, whether idle or mid-frame, the registered outputs take these values at that edge:
  - `TXD`=1, `TDRE`=1, `TX_BUSY`=0;
  - FSM=IDLE; counters 0; TDR and shift register 0.
  - A frame in progress is aborted with the line at 1.
- **Write latency.** `TDRE` falls on the edge that samples `TDR_WR`=1, so it reads 0 one cycle after the strobe.
- **Frame start.** `TXD` falls on the edge of the first `TICK16` at which IDLE sees `TDRE`=0 and `CTSB`=0. `TDRE` rises on that same edge.
- **Bit timing.** Each bit boundary sits exactly 16 `TICK16` pulses after the previous one; the 1.5-stop case uses 24. Cycles without `TICK16` do not advance any counter.
- **Frame length in ticks:** 16×(1+N+P) plus the stop length, where P=1 when parity is enabled.
- **Write on the load edge.** If `TDR_WR` coincides with a load edge, the shift register takes the old TDR value and the TDR takes the new data. `TDRE` stays 0, because the write wins the flag.
- **Reset priority.** `RESET` overrides all other inputs.

## Test plan
- **8N1 single byte.** Reset, `TICK16` every cycle, write 0x55, `R_WL`=00, `R_PME`=0, `R_SBN`=0 → `TXD` carries 0,1,0,1,0,1,0,1,0,1 in 16-cycle bits; frame is 160 ticks. `TDRE` reads 0 one cycle after the write and returns to 1 at the start-bit edge.
- **7E2.** Write 0xC3 with `R_WL`=01, `R_PME`=1, `R_PMC`=01, `R_SBN`=1 → data 1,1,0,0,0,0,1, then parity 1, then 32 ticks of stop. Repeat with odd parity → parity bit 0.
- **Stop-length exceptions.**
  - 5N2 → STOP lasts 24 ticks (frame is 120 ticks).
  - 8 data bits + mark parity with `R_SBN`=1 → one 16-tick stop bit, parity bit 1.
- **Back-to-back.** Write 0x01, then write 0x80 while the first frame is in DATA → second start bit begins on the tick immediately after the first frame's stop bit ends. Writing 0xFF while `TDRE`=0 replaces 0x80.
- **`CTSB` gating and sparse ticks.**
  - Drive `TICK16` every 7 cycles and hold `CTSB`=1 with data pending → `TXD` stays 1 indefinitely.
  - Drop `CTSB` → frame starts at the next tick.
  - Raise `CTSB` mid-frame → frame completes intact.
- **Reset mid-frame.** Assert `RESET`=0 during DATA bit 3 → at that edge `TXD`=1, `TDRE`=1, `TX_BUSY`=0. After release, no transmission occurs until a new write.

Source files
------------

// File: rtl/acia_tx_if.sv
// Transmit-side signal bundle for the ACIA: framing controls and data in, serial line and status out.
// The master modport is the register/timing side; the slave modport is the transmitter.
interface acia_tx_if;
    logic       TICK16;
    logic       TDR_WR;
    logic [7:0] TDR_IN;
    logic [1:0] R_WL;
    logic       R_SBN;
    logic       R_PME;
    logic [1:0] R_PMC;
    logic       CTSB;
    logic       TXD;
    logic       TDRE;
    logic       TX_BUSY;

    modport master (
        output TICK16, TDR_WR, TDR_IN, R_WL, R_SBN, R_PME, R_PMC, CTSB,
        input  TXD, TDRE, TX_BUSY
    );

    modport slave (
        input  TICK16, TDR_WR, TDR_IN, R_WL, R_SBN, R_PME, R_PMC, CTSB,
        output TXD, TDRE, TX_BUSY
    );
endinterface

// File: rtl/acia_tx.sv
// 6551-style transmitter: TDR plus shift register, 5-8 data bits, optional parity, 1/1.5/2 stop bits.
// TXD/TDRE/TX_BUSY are registered; frames start on a TICK16 with data pending and CTSB low, bits last 16 ticks.
module acia_tx (
    input  logic     XTLI,
    input  logic     RESET,
    acia_tx_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] shift_q, shift_d;
    logic       tdre_q, tdre_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic [1:0] wl_q, wl_d;
    logic       sbn_q, sbn_d;
    logic       pme_q, pme_d;
    logic       par_q, par_d;

    logic [7:0] ld_mask;
    logic       ld_par;
    logic [2:0] last_idx;
    logic [4:0] stop_last;
    logic       can_load;
    logic       load;

    // Parity is resolved once at load time from the live framing inputs, so it is latched with the frame.
    always_comb begin
        case (bus.R_WL)
            2'b00:   ld_mask = 8'hFF;
            2'b01:   ld_mask = 8'h7F;
            2'b10:   ld_mask = 8'h3F;
            default: ld_mask = 8'h1F;
        endcase
        case (bus.R_PMC)
            2'b00:   ld_par = ~^(tdr_q & ld_mask);
            2'b01:   ld_par = ^(tdr_q & ld_mask);
            2'b10:   ld_par = 1'b1;
            default: ld_par = 1'b0;
        endcase
    end

    assign last_idx = 3'd7 - {1'b0, wl_q};
    assign can_load = !tdre_q && !bus.CTSB;

    always_comb begin
        if (!sbn_q)                      stop_last = 5'd15;
        else if (wl_q == 2'b11 && !pme_q) stop_last = 5'd23;
        else if (wl_q == 2'b00 && pme_q)  stop_last = 5'd15;
        else                              stop_last = 5'd31;
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        tdr_d      = tdr_q;
        shift_d    = shift_q;
        tdre_d     = tdre_q;
        txd_d      = txd_q;
        wl_d       = wl_q;
        sbn_d      = sbn_q;
        pme_d      = pme_q;
        par_d      = par_q;
        load       = 1'b0;

        if (bus.TICK16) begin
            case (state_q)
                S_IDLE: begin
                    txd_d = 1'b1;
                    load  = can_load;
                end
                S_START: begin
                    if (tick_cnt_q == 5'd15) begin
                        state_d    = S_DATA;
                        tick_cnt_d = 5'd0;
                        bit_idx_d  = 3'd0;
                        txd_d      = shift_q[0];
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == 5'd15) begin
                        tick_cnt_d = 5'd0;
                        shift_d    = {1'b0, shift_q[7:1]};
                        bit_idx_d  = bit_idx_q + 3'd1;
                        if (bit_idx_q == last_idx) begin
                            state_d = pme_q ? S_PARITY : S_STOP;
                            txd_d   = pme_q ? par_q : 1'b1;
                        end else begin
                            // Next bit is shift_q[1] because the shift happens on this same edge.
                            txd_d = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == 5'd15) begin
                        state_d    = S_STOP;
                        tick_cnt_d = 5'd0;
                        txd_d      = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == stop_last) begin
                        if (can_load) begin
                            load = 1'b1;
                        end else begin
                            state_d    = S_IDLE;
                            tick_cnt_d = 5'd0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end

        if (load) begin
            state_d    = S_START;
            shift_d    = tdr_q;
            tdre_d     = 1'b1;
            tick_cnt_d = 5'd0;
            txd_d      = 1'b0;
            wl_d       = bus.R_WL;
            sbn_d      = bus.R_SBN;
            pme_d      = bus.R_PME;
            par_d      = ld_par;
        end

        // A write on the load edge still wins the empty flag; the shifter already took the old value.
        if (bus.TDR_WR) begin
            tdr_d  = bus.TDR_IN;
            tdre_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge XTLI) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= 5'd0;
            bit_idx_q  <= 3'd0;
            tdr_q      <= 8'd0;
            shift_q    <= 8'd0;
            tdre_q     <= 1'b1;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            wl_q       <= 2'b00;
            sbn_q      <= 1'b0;
            pme_q      <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tdr_q      <= tdr_d;
            shift_q    <= shift_d;
            tdre_q     <= tdre_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            wl_q       <= wl_d;
            sbn_q      <= sbn_d;
            pme_q      <= pme_d;
            par_q      <= par_d;
        end
    end

    assign bus.TXD     = txd_q;
    assign bus.TDRE    = tdre_q;
    assign bus.TX_BUSY = busy_q;
endmodule

// File: tb/tb_acia_tx.sv
// Scoreboarded bench for acia_tx: stimulus queues expected frames, a tick-driven monitor checks the line waveform.
module tb_acia_tx;
    typedef struct {
        logic [7:0] d;
        int         n;
        bit         pme;
        logic [1:0] pmc;
        bit         sbn;
        bit         b2b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tick_period;
    int   n_checks;
    int   n_fail;
    int   frames_sent;
    int   frames_done;
    bit   mon_in_frame;
    exp_t sb_q[$];

    acia_tx_if ifc();

    acia_tx dut (
        .XTLI  (clk),
        .RESET (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input bit cond, input string detail);
        n_checks++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic int stop_ticks(input exp_t e);
        if (!e.sbn) return 16;
        if (e.n == 5 && !e.pme) return 24;
        if (e.n == 8 && e.pme) return 16;
        return 32;
    endfunction

    function automatic int frame_len(input exp_t e);
        return 16 * (1 + e.n + (e.pme ? 1 : 0)) + stop_ticks(e);
    endfunction

    function automatic logic parity_bit(input exp_t e);
        int ones = 0;
        for (int i = 0; i < e.n; i++) ones += int'(e.d[i]);
        case (e.pmc)
            2'b00:   return (ones % 2 == 0);
            2'b01:   return (ones % 2 == 1);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_level(input exp_t e, input int t);
        int b = t / 16;
        if (b == 0) return 1'b0;
        if (b <= e.n) return e.d[b-1];
        if (e.pme && b == e.n + 1) return parity_bit(e);
        return 1'b1;
    endfunction

    initial begin : tick_gen
        int c = 0;
        ifc.TICK16 = 1'b0;
        forever begin
            @(negedge clk);
            ifc.TICK16 = (c == 0);
            c = (c + 1 >= tick_period) ? 0 : c + 1;
        end
    end

    initial begin : monitor
        exp_t cur;
        int   idx, len, bad_idx;
        bit   ok, ended;
        logic bad_txd, bad_busy, want;
        mon_in_frame = 1'b0;
        idx = 0; len = 0; bad_idx = 0; ok = 1'b1;
        bad_txd = 1'b0; bad_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n !== 1'b1) begin
                mon_in_frame = 1'b0;
                continue;
            end
            if (ifc.TICK16 !== 1'b1) continue;
            #1;
            ended = 1'b0;
            if (mon_in_frame) begin
                idx++;
                if (idx < len) begin
                    want = model_level(cur, idx);
                    if (ok && (ifc.TXD !== want || ifc.TX_BUSY !== 1'b1)) begin
                        ok = 1'b0; bad_idx = idx; bad_txd = ifc.TXD; bad_busy = ifc.TX_BUSY;
                    end
                end else begin
                    check("frame_wave", ok, $sformatf("data %h n=%0d tick %0d got TXD/BUSY %b/%b, want %b/1",
                          cur.d, cur.n, bad_idx, bad_txd, bad_busy, model_level(cur, bad_idx)));
                    check("frame_end", ifc.TXD === 1'b0 || ifc.TX_BUSY === 1'b0,
                          $sformatf("data %h after %0d ticks got TXD/BUSY %b/%b, want new start or idle",
                                    cur.d, len, ifc.TXD, ifc.TX_BUSY));
                    frames_done++;
                    mon_in_frame = 1'b0;
                    ended = 1'b1;
                end
            end
            if (!mon_in_frame && ifc.TXD === 1'b0) begin
                check("frame_expected", sb_q.size() != 0, "got a start bit, want none pending");
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    if (cur.b2b)
                        check("b2b_no_gap", ended, $sformatf("data %h start got gap, want start on tick after stop", cur.d));
                    idx = 0;
                    len = frame_len(cur);
                    ok = (ifc.TX_BUSY === 1'b1);
                    bad_idx = 0; bad_txd = ifc.TXD; bad_busy = ifc.TX_BUSY;
                    mon_in_frame = 1'b1;
                end
            end
        end
    end

    task automatic set_frame(input int n, input bit pme, input logic [1:0] pmc, input bit sbn);
        @(negedge clk);
        ifc.R_WL  = 2'(8 - n);
        ifc.R_PME = pme;
        ifc.R_PMC = pmc;
        ifc.R_SBN = sbn;
    endtask

    task automatic write_tdr(input logic [7:0] d);
        @(negedge clk);
        ifc.TDR_WR = 1'b1;
        ifc.TDR_IN = d;
        @(negedge clk);
        ifc.TDR_WR = 1'b0;
        check("tdre_after_write", ifc.TDRE === 1'b0, $sformatf("got TDRE %b, want 0", ifc.TDRE));
    endtask

    task automatic send(input logic [7:0] d, input bit b2b);
        exp_t e;
        e.d = d;
        e.n = 8 - int'(ifc.R_WL);
        e.pme = ifc.R_PME;
        e.pmc = ifc.R_PMC;
        e.sbn = ifc.R_SBN;
        e.b2b = b2b;
        sb_q.push_back(e);
        frames_sent++;
        write_tdr(d);
    endtask

    task automatic wait_tdre(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.TDRE === 1'b1) break;
        end
        check("tdre_rise", i < budget, $sformatf("got TDRE %b after %0d cycles, want 1", ifc.TDRE, budget));
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !mon_in_frame && ifc.TX_BUSY === 1'b0 && ifc.TDRE === 1'b1) break;
        end
        check("idle_reached", i < budget, $sformatf("got BUSY %b pending %0d after %0d cycles, want idle",
              ifc.TX_BUSY, sb_q.size(), budget));
    endtask

    initial begin : stimulus
        exp_t e;
        bit   bad;
        int   i;
        n_checks = 0; n_fail = 0; frames_sent = 0; frames_done = 0;
        tick_period = 1;
        rst_n = 1'b0;
        ifc.TDR_WR = 1'b0; ifc.TDR_IN = 8'h00;
        ifc.R_WL = 2'b00; ifc.R_SBN = 1'b0; ifc.R_PME = 1'b0; ifc.R_PMC = 2'b00;
        ifc.CTSB = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txd", ifc.TXD === 1'b1, $sformatf("got %b, want 1", ifc.TXD));
        check("reset_tdre", ifc.TDRE === 1'b1, $sformatf("got %b, want 1", ifc.TDRE));
        check("reset_busy", ifc.TX_BUSY === 1'b0, $sformatf("got %b, want 0", ifc.TX_BUSY));
        rst_n = 1'b1;

        // 8N1 0x55 with exact start-edge timing
        set_frame(8, 1'b0, 2'b00, 1'b0);
        send(8'h55, 1'b0);
        @(posedge clk); #1;
        check("start_tdre", ifc.TDRE === 1'b1, $sformatf("got TDRE %b at start edge, want 1", ifc.TDRE));
        check("start_txd", ifc.TXD === 1'b0, $sformatf("got TXD %b at start edge, want 0", ifc.TXD));
        wait_idle(400);

        // 7E2 and 7O2 on 0xC3
        set_frame(7, 1'b1, 2'b01, 1'b1);
        send(8'hC3, 1'b0);
        wait_idle(400);
        set_frame(7, 1'b1, 2'b00, 1'b1);
        send(8'hC3, 1'b0);
        wait_idle(400);

        // stop-length exceptions: 5N2 (1.5 stop) and 8M2 (single stop)
        set_frame(5, 1'b0, 2'b00, 1'b1);
        send(8'hB6, 1'b0);
        wait_idle(400);
        set_frame(8, 1'b1, 2'b10, 1'b1);
        send(8'h5A, 1'b0);
        wait_idle(400);

        // back-to-back with overwrite of the pending character
        set_frame(8, 1'b0, 2'b00, 1'b0);
        send(8'h01, 1'b0);
        wait_tdre(50);
        repeat (40) @(negedge clk);
        send(8'h80, 1'b1);
        e = sb_q.pop_back();
        e.d = 8'hFF;
        sb_q.push_back(e);
        write_tdr(8'hFF);
        wait_idle(800);

        // CTSB gating with sparse ticks
        tick_period = 7;
        ifc.CTSB = 1'b1;
        send(8'hA5, 1'b0);
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (ifc.TXD !== 1'b1 || ifc.TX_BUSY !== 1'b0 || ifc.TDRE !== 1'b0) bad = 1'b1;
        end
        check("cts_hold", !bad, "got line activity or TDRE change while CTSB=1, want hold");
        ifc.CTSB = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(posedge clk);
            if (ifc.TICK16 === 1'b1) break;
        end
        #1;
        check("cts_release_start", ifc.TX_BUSY === 1'b1 && ifc.TXD === 1'b0,
              $sformatf("got BUSY/TXD %b/%b at first tick, want 1/0", ifc.TX_BUSY, ifc.TXD));
        repeat (16 * 7 * 3) @(negedge clk);
        ifc.CTSB = 1'b1;
        wait_idle(2000);
        ifc.CTSB = 1'b0;

        // reset during data bit 3
        tick_period = 1;
        send(8'h3C, 1'b0);
        wait_tdre(50);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_txd", ifc.TXD === 1'b1, $sformatf("got %b, want 1", ifc.TXD));
        check("midreset_tdre", ifc.TDRE === 1'b1, $sformatf("got %b, want 1", ifc.TDRE));
        check("midreset_busy", ifc.TX_BUSY === 1'b0, $sformatf("got %b, want 0", ifc.TX_BUSY));
        frames_sent--;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (ifc.TXD !== 1'b1 || ifc.TX_BUSY !== 1'b0 || ifc.TDRE !== 1'b1) bad = 1'b1;
        end
        check("no_tx_after_reset", !bad, "got activity after reset, want quiet line");

        // randomized framing, data and tick spacing
        for (int k = 0; k < 24; k++) begin
            tick_period = int'($urandom_range(1, 3));
            set_frame(int'($urandom_range(5, 8)), 1'($urandom), 2'($urandom), 1'($urandom));
            send(8'($urandom), 1'b0);
            wait_tdre(2000);
        end
        wait_idle(3000);

        check("frame_count", frames_done == frames_sent,
              $sformatf("got %0d frames, want %0d", frames_done, frames_sent));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
